pipe_stage_reg: RTL

Parametrised pipeline-stage register that replaces the fixed-width, always-advancing MEM/WB flop bank with a valid/ready handshake, a two-entry skid buffer, flush and NOP squashing. It carries N data words, a control bundle and the destination register index between any two pipeline stages. It is instantiated first at MEM/WB, then at IF/ID, ID/EX and EX/MEM. It also counts output bubbles for performance debug.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/dff.sv | 18 +
 rtl/pipe_entry.sv | 38 +++
 rtl/pipe_stage_reg.sv | 100 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: control-bundle field
// positions, the squashed-control constant and entry width helpers.
package pipe_pkg;

  // Control bundle field positions (MEM/WB layout).
  localparam int unsigned CTRL_REGSRC_LSB = 0;
  localparam int unsigned CTRL_REGWRT     = 2;
  localparam int unsigned CTRL_BRANCH     = 3;

  // Squashed control: no register write, no branch. Sliced to CTRL_W at use.
  localparam int unsigned CTRL_MAX_W = 32;
  localparam logic [CTRL_MAX_W-1:0] CTRL_NOP = '0;

  // Payload held per entry, excluding the valid bit: nop + ctrl + wreg + data.
  function automatic int unsigned payload_w(input int unsigned num_data,
                                            input int unsigned data_w,
                                            input int unsigned ctrl_w,
                                            input int unsigned wreg_w);
    return 1 + ctrl_w + wreg_w + num_data * data_w;
  endfunction

  // Total entry width including the valid bit.
  function automatic int unsigned entry_w(input int unsigned num_data,
                                          input int unsigned data_w,
                                          input int unsigned ctrl_w,
                                          input int unsigned wreg_w);
    return 1 + payload_w(num_data, data_w, ctrl_w, wreg_w);
  endfunction

  // Default MEM/WB entry layout.
  localparam int unsigned MEMWB_ENTRY_W = entry_w(4, 16, 4, 3);

  typedef struct packed {
    logic        valid;
    logic        nop;
    logic [3:0]  ctrl;
    logic [2:0]  wreg;
    logic [63:0] data;
  } memwb_entry_t;

endpackage

// File: rtl/dff.sv
// Enabled D flip-flop cell with synchronous active-high reset to zero.
module dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset clears, otherwise capture d when enabled.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_entry.sv
// One pipeline entry: valid bit plus payload, with load and a synchronous
// clear of the valid bit only (payload is retained on clear).
module pipe_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d_pay,
  output logic         q_valid,
  output logic [W-1:0] q_pay
);

  logic valid_d;

  // Clear wins over load; a load always marks the entry valid.
  always_comb begin
    valid_d = !clr;
  end

  dff #(.W(1)) u_valid (
    .clk (clk),
    .rst (rst),
    .en  (load | clr),
    .d   (valid_d),
    .q   (q_valid)
  );

  dff #(.W(W)) u_pay (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   (d_pay),
    .q   (q_pay)
  );

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer,
// flush, NOP control squashing and a saturating output-bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_DATA = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CTRL_W   = 4,
  parameter int unsigned WREG_W   = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_nop,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [WREG_W-1:0]          in_wreg,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_nop,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [WREG_W-1:0]          out_wreg,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int unsigned DW    = NUM_DATA * DATA_W;
  localparam int unsigned PAY_W = payload_w(NUM_DATA, DATA_W, CTRL_W, WREG_W);

  logic [PAY_W-1:0] in_pay, main_pay, skid_pay, main_pay_d;
  logic             main_v, skid_v;
  logic             accept, drain;
  logic             main_load, main_clr, skid_load, skid_clr;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  assign in_pay   = {in_nop, in_ctrl, in_wreg, in_data};
  // Depends only on the skid valid flop, so no path from out_ready.
  assign in_ready = !skid_v;

  // Steering: main refills from skid when it holds a beat, else from input.
  // Skid is only ever valid while main is valid, and accept is impossible
  // while skid is valid, so the two refill sources never collide.
  always_comb begin
    accept     = in_valid & in_ready;
    drain      = main_v & out_ready;
    main_pay_d = skid_v ? skid_pay : in_pay;
    main_load  = (drain & skid_v) | (accept & (!main_v | drain));
    main_clr   = flush | (drain & !skid_v & !accept);
    skid_load  = accept & main_v & !drain;
    skid_clr   = flush | (drain & skid_v);
  end

  pipe_entry #(.W(PAY_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clr     (main_clr),
    .d_pay   (main_pay_d),
    .q_valid (main_v),
    .q_pay   (main_pay)
  );

  pipe_entry #(.W(PAY_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clr     (skid_clr),
    .d_pay   (in_pay),
    .q_valid (skid_v),
    .q_pay   (skid_pay)
  );

  // Present the main entry, squashing control for bubble beats.
  always_comb begin
    out_valid = main_v;
    out_nop   = main_pay[PAY_W-1];
    out_wreg  = main_pay[DW +: WREG_W];
    out_data  = main_pay[DW-1:0];
    out_ctrl  = out_nop ? CTRL_NOP[CTRL_W-1:0] : main_pay[DW+WREG_W +: CTRL_W];
  end

  // Next bubble count: saturating increment on starved cycles.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !main_v && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // Bubble counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule
